z88_rtc_timer: RTL and testbench

- Parametrised successor of the Blink RTC/timer logic: prescaler, cascaded 5 ms / second / minute counters, sticky timer status (TSTA), mask (TMK) and rtc_int output.
- Sits behind the Blink IO decoder on the mck domain; the parent muxes rdata into the IO read path and ORs rtc_int into intb.
- New over the previous generation:
  - edge-qualified IO strobes, so a level strobe counts as one access;
  - coherent multi-byte time read via a snapshot taken on a TIM0 read;
  - set-wins arbitration on TSTA;
  - parametrised divider and minute width.

---
 rtl/z88_blink_pkg.sv | 46 ++++
 rtl/z88_rtc_timer_if.sv | 13 +
 rtl/z88_rtc_prescaler.sv | 45 ++++
 rtl/z88_rtc_timer.sv | 164 ++++++++++++++++
 tb/tb_z88_rtc_timer.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/z88_blink_pkg.sv
// Blink IO port map, TSTA bit layout and read-port decode for the RTC/timer block.
package z88_blink_pkg;

    localparam int unsigned IO_AW  = 8;
    localparam int unsigned IO_DW  = 8;
    localparam int unsigned TSTA_W = 3;

    localparam logic [IO_AW-1:0] P_TACK = 8'hB4;
    localparam logic [IO_AW-1:0] P_TMK  = 8'hB5;
    localparam logic [IO_AW-1:0] P_TSTA = 8'hB5;
    localparam logic [IO_AW-1:0] P_TIM0 = 8'hD0;
    localparam logic [IO_AW-1:0] P_TIM1 = 8'hD1;
    localparam logic [IO_AW-1:0] P_TIM2 = 8'hD2;
    localparam logic [IO_AW-1:0] P_TIM3 = 8'hD3;
    localparam logic [IO_AW-1:0] P_TIM4 = 8'hD4;

    localparam int unsigned TSTA_TICK = 0;
    localparam int unsigned TSTA_SEC  = 1;
    localparam int unsigned TSTA_MIN  = 2;

    typedef enum logic [2:0] {
        RD_NONE,
        RD_TSTA,
        RD_TIM0,
        RD_TIM1,
        RD_TIM2,
        RD_TIM3,
        RD_TIM4
    } rd_sel_e;

    // Map an IO address onto the readable register it selects.
    function automatic rd_sel_e rd_decode(input logic [IO_AW-1:0] a);
        rd_sel_e sel;
        case (a)
            P_TSTA:  sel = RD_TSTA;
            P_TIM0:  sel = RD_TIM0;
            P_TIM1:  sel = RD_TIM1;
            P_TIM2:  sel = RD_TIM2;
            P_TIM3:  sel = RD_TIM3;
            P_TIM4:  sel = RD_TIM4;
            default: sel = RD_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/z88_rtc_timer_if.sv
// IO decoder side of the RTC/timer: level strobes, address, write and read data.
interface z88_rtc_timer_if;
    import z88_blink_pkg::*;

    logic             io_wr;
    logic             io_rd;
    logic [IO_AW-1:0] addr;
    logic [IO_DW-1:0] wdata;
    logic [IO_DW-1:0] rdata;

    modport master (output io_wr, output io_rd, output addr, output wdata, input rdata);
    modport slave  (input io_wr, input io_rd, input addr, input wdata, output rdata);
endinterface

// File: rtl/z88_rtc_prescaler.sv
// Divides mck down to the 5 ms tick; restim holds the divider at zero.
module z88_rtc_prescaler #(
    parameter int unsigned TICK_DIV = 49152
) (
    input  logic mck,
    input  logic rin_n,
    input  logic restim,
    output logic tick_ev_c,
    output logic tick
);

    localparam int unsigned      PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    // Event fires in the terminal-count cycle; the tick pulse follows one cycle later.
    always_comb begin
        presc_d   = presc_q;
        tick_ev_c = 1'b0;
        if (restim) begin
            presc_d = '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_d   = '0;
            tick_ev_c = 1'b1;
        end else begin
            presc_d = presc_q + PW'(1);
        end
        tick_d = tick_ev_c;
    end

    assign tick = tick_q;

endmodule

// File: rtl/z88_rtc_timer.sv
// Blink RTC/timer: tick/second/minute cascade, sticky TSTA with mask, and the
// IO register file with a coherent snapshot of the time taken on each TIM0 read.
module z88_rtc_timer
    import z88_blink_pkg::*;
#(
    parameter int unsigned TICK_DIV = 49152,
    parameter int unsigned TIM0_MOD = 200,
    parameter int unsigned TIM1_MOD = 60,
    parameter int unsigned TIMM_W   = 21
) (
    input  logic               mck,
    input  logic               rin_n,
    input  logic               restim,
    z88_rtc_timer_if.slave     io,
    output logic               rtc_int,
    output logic               tick
);

    localparam int unsigned      T0W       = (TIM0_MOD > 1) ? $clog2(TIM0_MOD) : 1;
    localparam int unsigned      T1W       = (TIM1_MOD > 1) ? $clog2(TIM1_MOD) : 1;
    localparam logic [T0W-1:0]   TIM0_LAST = T0W'(TIM0_MOD - 1);
    localparam logic [T1W-1:0]   TIM1_LAST = T1W'(TIM1_MOD - 1);

    logic                  tick_ev_c;
    logic [TSTA_W-1:0]     ev_c;

    logic [T0W-1:0]        tim0_q, tim0_d;
    logic [T1W-1:0]        tim1_q, tim1_d;
    logic [TIMM_W-1:0]     timm_q, timm_d;
    logic [TSTA_W-1:0]     tsta_q, tsta_d;
    logic [TSTA_W-1:0]     tmk_q, tmk_d;
    logic [T1W-1:0]        sh_tim1_q, sh_tim1_d;
    logic [TIMM_W-1:0]     sh_timm_q, sh_timm_d;
    logic [IO_DW-1:0]      rdata_q, rdata_d;
    logic                  io_wr_q, io_rd_q;

    logic                  wr_p_c, rd_p_c, tack_c, tmk_we_c;
    logic [23:0]           sh_timm_ext_c;
    logic                  unused_wdata_hi;

    z88_rtc_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .mck       (mck),
        .rin_n     (rin_n),
        .restim    (restim),
        .tick_ev_c (tick_ev_c),
        .tick      (tick)
    );

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            tim0_q    <= '0;
            tim1_q    <= '0;
            timm_q    <= '0;
            tsta_q    <= '0;
            tmk_q     <= '0;
            sh_tim1_q <= '0;
            sh_timm_q <= '0;
            rdata_q   <= '0;
            io_wr_q   <= 1'b0;
            io_rd_q   <= 1'b0;
        end else begin
            tim0_q    <= tim0_d;
            tim1_q    <= tim1_d;
            timm_q    <= timm_d;
            tsta_q    <= tsta_d;
            tmk_q     <= tmk_d;
            sh_tim1_q <= sh_tim1_d;
            sh_timm_q <= sh_timm_d;
            rdata_q   <= rdata_d;
            io_wr_q   <= io_wr_d();
            io_rd_q   <= io_rd_d();
        end
    end

    function automatic logic io_wr_d();
        return io.io_wr;
    endfunction

    function automatic logic io_rd_d();
        return io.io_rd;
    endfunction

    // A level strobe acts once, on its rising edge.
    assign wr_p_c   = io.io_wr & ~io_wr_q;
    assign rd_p_c   = io.io_rd & ~io_rd_q;
    assign tack_c   = wr_p_c && (io.addr == P_TACK);
    assign tmk_we_c = wr_p_c && (io.addr == P_TMK);

    // Tick -> second -> minute cascade; the minute counter wraps without an event.
    always_comb begin
        ev_c            = '0;
        tim0_d          = tim0_q;
        tim1_d          = tim1_q;
        timm_d          = timm_q;
        ev_c[TSTA_TICK] = tick_ev_c;
        if (restim) begin
            tim0_d = '0;
            tim1_d = '0;
            timm_d = '0;
        end else if (tick_ev_c) begin
            if (tim0_q == TIM0_LAST) begin
                tim0_d         = '0;
                ev_c[TSTA_SEC] = 1'b1;
                if (tim1_q == TIM1_LAST) begin
                    tim1_d         = '0;
                    ev_c[TSTA_MIN] = 1'b1;
                    timm_d         = timm_q + TIMM_W'(1);
                end else begin
                    tim1_d = tim1_q + T1W'(1);
                end
            end else begin
                tim0_d = tim0_q + T0W'(1);
            end
        end
    end

    // Sticky status: a new event beats a simultaneous acknowledge.
    always_comb begin
        tsta_d = tsta_q;
        tmk_d  = tmk_q;
        for (int unsigned i = 0; i < TSTA_W; i++) begin
            if (ev_c[i]) begin
                tsta_d[i] = 1'b1;
            end else if (tack_c && io.wdata[i]) begin
                tsta_d[i] = 1'b0;
            end
        end
        if (tmk_we_c) begin
            tmk_d = io.wdata[TSTA_W-1:0];
        end
    end

    assign sh_timm_ext_c = 24'(sh_timm_q);

    // Read port; a TIM0 read freezes tim1/timm so D1..D4 belong to the same instant.
    always_comb begin
        rdata_d   = rdata_q;
        sh_tim1_d = sh_tim1_q;
        sh_timm_d = sh_timm_q;
        if (rd_p_c) begin
            case (rd_decode(io.addr))
                RD_TSTA: rdata_d = IO_DW'(tsta_q);
                RD_TIM0: begin
                    rdata_d   = IO_DW'(tim0_q);
                    sh_tim1_d = tim1_q;
                    sh_timm_d = timm_q;
                end
                RD_TIM1: rdata_d = IO_DW'(sh_tim1_q);
                RD_TIM2: rdata_d = sh_timm_ext_c[7:0];
                RD_TIM3: rdata_d = sh_timm_ext_c[15:8];
                RD_TIM4: rdata_d = sh_timm_ext_c[23:16];
                default: rdata_d = rdata_q;
            endcase
        end
    end

    assign unused_wdata_hi = ^io.wdata[IO_DW-1:TSTA_W];

    assign io.rdata = rdata_q;
    assign rtc_int  = |(tsta_q & tmk_q);

endmodule

// File: tb/tb_z88_rtc_timer.sv
// Scenario bench for z88_rtc_timer with a small divider so whole minutes elapse quickly.
module tb_z88_rtc_timer;
    import z88_blink_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int TIM0_MOD = 3;
    localparam int TIM1_MOD = 2;
    localparam int TIMM_W   = 9;

    logic mck    = 1'b0;
    logic rin_n  = 1'b0;
    logic restim = 1'b0;
    logic rtc_int;
    logic tick;

    z88_rtc_timer_if bus ();

    z88_rtc_timer #(
        .TICK_DIV (TICK_DIV),
        .TIM0_MOD (TIM0_MOD),
        .TIM1_MOD (TIM1_MOD),
        .TIMM_W   (TIMM_W)
    ) dut (
        .mck     (mck),
        .rin_n   (rin_n),
        .restim  (restim),
        .io      (bus),
        .rtc_int (rtc_int),
        .tick    (tick)
    );

    always #5 mck = ~mck;

    // Edges since reset release; after edge n, floor(n/TICK_DIV) ticks have occurred.
    int cyc;
    always @(posedge mck or negedge rin_n) begin
        if (!rin_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] val;
        string      name;
    } sb_t;
    sb_t sb_q[$];

    int sh_tim1 = 0;
    int sh_timm = 0;

    function automatic int m_tim0(input int t);
        return t % TIM0_MOD;
    endfunction
    function automatic int m_tim1(input int t);
        return (t / TIM0_MOD) % TIM1_MOD;
    endfunction
    function automatic int m_timm(input int t);
        return (t / (TIM0_MOD * TIM1_MOD)) % (1 << TIMM_W);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge mck);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic reset_dut();
        rin_n      = 1'b0;
        restim     = 1'b0;
        bus.io_wr  = 1'b0;
        bus.io_rd  = 1'b0;
        bus.addr   = 8'h00;
        bus.wdata  = 8'h00;
        sh_tim1    = 0;
        sh_timm    = 0;
        step(2);
        rin_n = 1'b1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.io_wr = 1'b1;
        step(1);
        bus.io_wr = 1'b0;
    endtask

    // One-edge read pulse plus a low edge; the result is scored against the queued expectation.
    task automatic rd(input logic [7:0] a, input logic [7:0] e, input string nm);
        sb_t x;
        x.val  = e;
        x.name = nm;
        sb_q.push_back(x);
        bus.addr  = a;
        bus.io_rd = 1'b1;
        step(1);
        bus.io_rd = 1'b0;
        step(1);
        x = sb_q.pop_front();
        checks++;
        if (bus.rdata !== x.val) begin
            errors++;
            $display("FAIL %s: rdata=%02h expected=%02h (cyc %0d)", x.name, bus.rdata, x.val, cyc);
        end
    endtask

    // Expected time read derived from the elapsed tick count and the bench's own snapshot.
    task automatic rd_time(input logic [7:0] a, input string nm);
        int t;
        logic [7:0] e;
        t = cyc / TICK_DIV;
        case (a)
            P_TIM0: begin
                e       = 8'(m_tim0(t));
                sh_tim1 = m_tim1(t);
                sh_timm = m_timm(t);
            end
            P_TIM1:  e = 8'(sh_tim1);
            P_TIM2:  e = 8'(sh_timm % 256);
            P_TIM3:  e = 8'((sh_timm / 256) % 256);
            P_TIM4:  e = 8'((sh_timm / 65536) % 256);
            default: e = 8'h00;
        endcase
        rd(a, e, nm);
    endtask

    task automatic test_reset();
        reset_dut();
        step_to(12);
        wr(P_TMK, 8'h07);
        checks++;
        if (rtc_int !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_int: rtc_int=%b expected=1", rtc_int);
        end
        step(1);
        rd(P_TSTA, 8'h03, "reset_pre_tsta");
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_tick: tick=%b expected=1", tick);
        end
        #3 rin_n = 1'b0;
        #1;
        checks++;
        if (bus.rdata !== 8'h00 || tick !== 1'b0 || rtc_int !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: rdata=%02h tick=%b rtc_int=%b expected 00/0/0",
                     bus.rdata, tick, rtc_int);
        end
        @(posedge mck);
        #1;
        rin_n   = 1'b1;
        sh_tim1 = 0;
        sh_timm = 0;
        rd(P_TSTA, 8'h00, "reset_tsta");
        rd_time(P_TIM0, "reset_tim0");
        rd_time(P_TIM2, "reset_tim2");
    endtask

    task automatic test_cascade();
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            step(1);
            checks++;
            if (tick !== ((cyc % TICK_DIV) == 0)) begin
                errors++;
                $display("FAIL cascade_tick: tick=%b expected=%b (cyc %0d)",
                         tick, ((cyc % TICK_DIV) == 0), cyc);
            end
        end
        rd(P_TSTA, 8'h03, "cascade_tsta_3ticks");
        rd_time(P_TIM0, "cascade_tim0_3ticks");
        step_to(24);
        rd(P_TSTA, 8'h07, "cascade_tsta_6ticks");
        rd_time(P_TIM0, "cascade_tim0_6ticks");
        rd_time(P_TIM2, "cascade_timm_6ticks");
        rd_time(P_TIM1, "cascade_tim1_6ticks");
    endtask

    task automatic test_mask();
        reset_dut();
        step_to(4);
        wr(P_TMK, 8'h02);
        checks++;
        if (rtc_int !== 1'b0) begin
            errors++;
            $display("FAIL mask_tick_only: rtc_int=%b expected=0", rtc_int);
        end
        step_to(11);
        checks++;
        if (rtc_int !== 1'b0) begin
            errors++;
            $display("FAIL mask_before_sec: rtc_int=%b expected=0", rtc_int);
        end
        step(1);
        checks++;
        if (rtc_int !== 1'b1) begin
            errors++;
            $display("FAIL mask_sec_event: rtc_int=%b expected=1", rtc_int);
        end
        wr(P_TACK, 8'h02);
        checks++;
        if (rtc_int !== 1'b0) begin
            errors++;
            $display("FAIL mask_tack: rtc_int=%b expected=0", rtc_int);
        end
        step(1);
        rd(P_TSTA, 8'h01, "mask_tsta_after_tack");
    endtask

    task automatic test_set_wins();
        reset_dut();
        step_to(3);
        wr(P_TACK, 8'h01);
        step(1);
        rd(P_TSTA, 8'h01, "setwins_tsta");
        step(1);
        wr(P_TACK, 8'h01);
        rd(P_TSTA, 8'h00, "tack_clears_tsta");
    endtask

    task automatic test_level_strobe();
        reset_dut();
        step_to(12);
        bus.addr  = P_TACK;
        bus.wdata = 8'h07;
        bus.io_wr = 1'b1;
        step(2);
        rd(P_TSTA, 8'h00, "level_first_edge_clear");
        bus.addr = P_TACK;
        step(6);
        bus.io_wr = 1'b0;
        rd(P_TSTA, 8'h01, "level_single_clear");
    endtask

    task automatic test_shadow();
        reset_dut();
        step_to(132);
        rd_time(P_TIM0, "shadow_tim0_a");
        step_to(144);
        rd_time(P_TIM1, "shadow_tim1_a");
        rd_time(P_TIM2, "shadow_timm_a");
        rd_time(P_TIM0, "shadow_tim0_b");
        rd_time(P_TIM1, "shadow_tim1_b");
        rd_time(P_TIM2, "shadow_timm_b");
        rd_time(P_TIM3, "shadow_tim3_b");
        rd_time(P_TIM4, "shadow_tim4_b");
    endtask

    task automatic test_restim();
        reset_dut();
        step_to(12);
        restim = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(1);
            checks++;
            if (tick !== 1'b0) begin
                errors++;
                $display("FAIL restim_hold_tick: tick=%b expected=0 (cyc %0d)", tick, cyc);
            end
        end
        restim  = 1'b0;
        sh_tim1 = 0;
        sh_timm = 0;
        rd(P_TIM0, 8'h00, "restim_tim0_zero");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tick !== (i == 2)) begin
                errors++;
                $display("FAIL restim_first_tick: tick=%b expected=%b (cyc %0d)", tick, (i == 2), cyc);
            end
            if (i < 2) step(1);
        end
        rd(P_TIM1, 8'h00, "restim_tim1_zero");
        rd(P_TSTA, 8'h03, "restim_tsta_kept");
    endtask

    task automatic test_timm_wrap();
        reset_dut();
        step_to(12284);
        rd_time(P_TIM0, "wrap_tim0_pre");
        rd_time(P_TIM2, "wrap_timm_lo_pre");
        rd_time(P_TIM3, "wrap_timm_hi_pre");
        wr(P_TACK, 8'h07);
        step(1);
        rd_time(P_TIM0, "wrap_tim0_post");
        rd_time(P_TIM2, "wrap_timm_lo_post");
        rd_time(P_TIM4, "wrap_timm_top_post");
        rd(P_TSTA, 8'h01, "wrap_no_spurious");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cascade();
        test_mask();
        test_set_wins();
        test_level_strobe();
        test_shadow();
        test_restim();
        test_timm_wrap();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
